// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter that lets NUM_REQ byte requesters share a single UART
//   transmitter. One byte is accepted at a time. It is handed to the UART with a
//   one-cycle enable_tx strobe. The block then waits for the UART's tx_done pulse
//   and inserts GAP_CYCLES idle clocks before the next byte is accepted.
//
// Parameters
//   NUM_REQ        number of requesters (2..8)
//   GAP_CYCLES     idle clocks after each completed frame (0 allowed)
//   TIMEOUT_CYCLES WAIT watchdog limit (only with UART_SCHED_TIMEOUT_EN)
//
// Optional feature
//   `define UART_SCHED_TIMEOUT_EN adds a watchdog in WAIT. If tx_done does not
//   arrive within TIMEOUT_CYCLES clocks, timeout_err pulses for one cycle and the
//   frame is abandoned. Without the macro, WAIT waits forever and timeout_err is
//   tied to 0.
//
// Ports
//   clk          rising-edge clock shared with the UART
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester byte pending; held with its data until accepted
//   req_data     requester i byte at [8i+7:8i]
//   req_ready    one-hot accept strobe, asserted only in IDLE
//   enable_tx    one-cycle start strobe to the UART
//   tx_data      byte presented to the UART, stable from START until WAIT exits
//   tx_done      one-cycle frame-complete pulse from the UART
//   busy         high in any state other than IDLE
//   grant_id     index of the current or last granted requester
//   timeout_err  one-cycle watchdog abort pulse
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 enable_tx,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t           state, state_nxt;
  logic [2:0]       last_grant;
  logic [2:0]       win_idx;
  logic             win_found;
  logic             accept;
  logic [7:0]       valid_ext;
  logic [63:0]      data_ext;
  logic [GAP_W-1:0] gap_cnt;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            wait_expire;
`endif

  // Widen the request buses to the 8-requester maximum.
  // This lets a 3-bit index select from them for any NUM_REQ.
  assign valid_ext = 8'(req_valid);
  assign data_ext  = 64'(req_data);
  assign busy      = (state != IDLE);

  // Rotating priority: the first valid requester at or above last_grant+1, wrapping.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!win_found && valid_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    enable_tx = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
    wait_expire = 1'b0;
`endif
    case (state)
      IDLE: begin
        // rst_n gating keeps req_ready low while reset is held with requests pending.
        if (win_found && rst_n) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        enable_tx = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (tx_done) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
`ifdef UART_SCHED_TIMEOUT_EN
        else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          wait_expire = 1'b1;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_ready[i] = accept && (win_idx == 3'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= 3'(NUM_REQ - 1);
      gap_cnt    <= '0;
    end else begin
      if (accept) begin
        tx_data    <= data_ext[{win_idx, 3'b000} +: 8];
        grant_id   <= win_idx;
        last_grant <= win_idx;
      end
      // Cleared outside GAP and released at GAP_CYCLES-1, so it never wraps.
      if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else              gap_cnt <= '0;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wait_expire;
      if (state == WAIT) wait_cnt <= wait_cnt + TO_W'(1);
      else               wait_cnt <= '0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler.
// It applies a table of directed frames, then hand-written reset, idle-done and
// gap-done sequences, then randomized frames.
// Expected grants for the random frames come from a rotating-priority model.
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int G   = 16;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           enable_tx;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic           busy;
  logic [2:0]     grant_id;
  logic           timeout_err;

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enable_tx(enable_tx), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int model_lg = N - 1;
  int prev_acc = -1, prev_f = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          flen;
    int          exp_g;
    logic [7:0]  exp_b;
    bit          hold;
    logic [7:0]  nb;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Grant rule: the first pending requester after the last winner, wrapping around.
  function automatic int model_winner(input logic [3:0] v, input int lg);
    for (int k = 1; k <= N; k++)
      if (v[(lg + k) % N]) return (lg + k) % N;
    return -1;
  endfunction

  // One complete frame: accept, start, flen quiet WAIT cycles, tx_done, then GAP.
  task automatic do_frame(input int exp_g, input logic [7:0] exp_b, input int flen,
                          input bit hold, input logic [7:0] nb, input bit poke);
    int k;
    #1;
    k = 0;
    while (req_ready == '0 && k < 50) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check("accept_ready", 32'(req_ready), 32'd1 << exp_g);
    if (req_ready == '0) return;
    if (prev_acc >= 0) check("accept_spacing", cyc - prev_acc, 3 + G + prev_f);
    prev_acc = cyc;
    prev_f   = flen;
    @(posedge clk); #1;
    if (hold) req_data[8*exp_g +: 8] = nb;
    else      req_valid[exp_g] = 1'b0;
    @(negedge clk);
    check("start_strobe", {enable_tx, busy, req_ready}, {1'b1, 1'b1, 4'b0});
    check("tx_data", 32'(tx_data), 32'(exp_b));
    check("grant_id", 32'(grant_id), exp_g);
    for (int i = 0; i < flen; i++) begin
      @(posedge clk); @(negedge clk);
      check("wait_hold", {enable_tx, busy, req_ready, timeout_err, tx_data},
            {1'b0, 1'b1, 4'b0, 1'b0, exp_b});
    end
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      check("gap_quiet", {enable_tx, req_ready}, 5'b0);
      k++;
      @(posedge clk); #1 tx_done = poke && (k == 2);
      @(negedge clk);
    end
    tx_done = 1'b0;
    check("gap_length", k, G);
  endtask

  initial begin
    int k;
    tbl[0] = '{4'b0100, 32'h00A5_0000, 40, 2, 8'hA5, 1'b0, 8'h00};
    tbl[1] = '{4'b1111, 32'h4433_2211,  3, 3, 8'h44, 1'b0, 8'h00};
    tbl[2] = '{4'b1111, 32'h8877_6655,  3, 0, 8'h55, 1'b0, 8'h00};
    tbl[3] = '{4'b1111, 32'hCCBB_AA99,  3, 1, 8'hAA, 1'b0, 8'h00};
    tbl[4] = '{4'b0010, 32'h0000_1100,  0, 1, 8'h11, 1'b1, 8'h22};
    tbl[5] = '{4'b0010, 32'h0000_2200,  0, 1, 8'h22, 1'b0, 8'h00};
    tbl[6] = '{4'b0001, 32'h0000_00F0,  5, 0, 8'hF0, 1'b0, 8'h00};
    tbl[7] = '{4'b1001, 32'h7E00_00E7,  2, 3, 8'h7E, 1'b0, 8'h00};
    tbl[8] = '{4'b1001, 32'h7E00_00E7,  1, 0, 8'hE7, 1'b0, 8'h00};

    // Reset held with requests pending: all outputs stay at reset values.
    rst_n = 1'b0; req_valid = 4'b1111; req_data = 32'h4433_2211; tx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {req_ready, enable_tx, tx_data, busy, grant_id, timeout_err}, 32'd0);
    end
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int v = 0; v < 9; v++) begin
      req_valid = tbl[v].valid;
      req_data  = tbl[v].data;
      do_frame(tbl[v].exp_g, tbl[v].exp_b, tbl[v].flen, tbl[v].hold, tbl[v].nb, 1'b0);
      model_lg = tbl[v].exp_g;
    end

    // tx_done pulsed in IDLE is ignored
    req_valid = '0;
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_done_ignored", {busy, enable_tx, req_ready}, 6'b0);
    end

    // tx_done pulsed during GAP is ignored: GAP length unchanged
    prev_acc = -1;
    req_valid = 4'b0100; req_data = 32'h005A_0000;
    do_frame(2, 8'h5A, 4, 1'b0, 8'h00, 1'b1);

    // Reset asserted for 3 clocks while in WAIT
    req_valid = 4'b1000; req_data = 32'h3C00_0000;
    #1;
    k = 0;
    while (req_ready == '0 && k < 50) begin @(posedge clk); @(negedge clk); k++; end
    check("midreset_accept", 32'(req_ready), 32'b1000);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("midreset_start", {enable_tx, tx_data}, {1'b1, 8'h3C});
    for (int i = 0; i < 3; i++) begin @(posedge clk); @(negedge clk); end
    req_valid = 4'b1111; req_data = 32'h4433_2211;
    @(posedge clk); #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_outputs", {req_ready, enable_tx, tx_data, busy, grant_id, timeout_err}, 32'd0);
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    model_lg = N - 1;
    prev_acc = -1;

    // All four requesters held valid: grants 0,1,2,3,0, each byte once
    do_frame(0, 8'h11, 2, 1'b1, 8'h51, 1'b0);
    do_frame(1, 8'h22, 2, 1'b1, 8'h52, 1'b0);
    do_frame(2, 8'h33, 2, 1'b1, 8'h53, 1'b0);
    do_frame(3, 8'h44, 2, 1'b1, 8'h54, 1'b0);
    do_frame(0, 8'h51, 2, 1'b1, 8'h61, 1'b0);
    model_lg = 0;

    // Randomized frames against the rotating-priority model
    for (int it = 0; it < 40; it++) begin
      logic [3:0]  m;
      logic [31:0] d;
      int          w, f;
      bit          h;
      m = 4'($urandom_range(1, 15));
      d = $urandom;
      f = $urandom_range(0, 30);
      h = 1'($urandom_range(0, 1));
      req_valid = m;
      req_data  = d;
      w = model_winner(m, model_lg);
      do_frame(w, d[8*w +: 8], f, h, 8'($urandom), 1'b0);
      model_lg = w;
    end

`ifdef UART_SCHED_TIMEOUT_EN
    // Watchdog: tx_done withheld, so the frame is aborted after TMO WAIT clocks
    req_valid = 4'b0001; req_data = 32'h0000_00C3;
    #1;
    k = 0;
    while (req_ready == '0 && k < 200) begin @(posedge clk); @(negedge clk); k++; end
    check("to_accept", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("to_start", enable_tx, 1);
    k = 0;
    @(posedge clk); @(negedge clk);
    while (!timeout_err && k < 200) begin k++; @(posedge clk); @(negedge clk); end
    check("timeout_latency", k, TMO);
    check("timeout_busy", busy, 1);
    k = 1;
    @(posedge clk); @(negedge clk);
    check("timeout_pulse_width", timeout_err, 0);
    while (busy && k < 200) begin k++; @(posedge clk); @(negedge clk); end
    check("timeout_gap_length", k, G);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
